// File: rtl/wb_queue.sv
// wb_queue: in-order writeback buffer feeding register file write port 3, with pending-write queries.
// Optional macro WBQ_FWD_EN adds fwd1/fwd2, the youngest pending data for each query address.
`default_nettype none

module wb_queue #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [4:0]               in_addr,
  input  logic [63:0]              in_data,
  input  logic                     hold,
  output logic                     we3,
  output logic [4:0]               wa3,
  output logic [63:0]              wd3,
  input  logic [4:0]               qa1,
  input  logic [4:0]               qa2,
  output logic                     busy1,
  output logic                     busy2,
`ifdef WBQ_FWD_EN
  output logic [63:0]              fwd1,
  output logic [63:0]              fwd2,
`endif
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [4:0]    c_XZR  = 5'd31;
  localparam logic [CW-1:0] c_FULL = CW'(DEPTH);

  logic [PW-1:0] r_head;
  logic [PW-1:0] r_tail;
  logic [CW-1:0] r_count;
  logic [4:0]    r_addr [DEPTH];
  logic [63:0]   r_data [DEPTH];

  logic             w_accept;
  logic             w_push;
  logic             w_pop;
  logic [DEPTH-1:0] w_incl;
  logic [DEPTH-1:0] w_hit1;
  logic [DEPTH-1:0] w_hit2;

  assign in_ready = (r_count != c_FULL);
  assign w_accept = in_valid && in_ready;
  assign w_push   = w_accept && (in_addr != c_XZR);
  assign we3      = (r_count != '0) && !hold;
  assign w_pop    = we3;
  assign wa3      = (r_count != '0) ? r_addr[r_head] : 5'd0;
  assign wd3      = (r_count != '0) ? r_data[r_head] : 64'd0;
  assign count    = r_count;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_tail <= r_tail + PW'(1);
      if (w_pop)  r_head <= r_head + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Payload storage carries no reset; occupancy alone decides which slots are meaningful.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_addr[r_tail] <= in_addr;
      r_data[r_tail] <= in_data;
    end
  end

  // A slot takes part in queries when occupied, except a head already being written this cycle.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    logic [PW-1:0] w_age;
    assign w_age       = PW'(gi) - r_head;
    assign w_incl[gi]  = ({1'b0, w_age} < r_count) && !(we3 && (PW'(gi) == r_head));
    assign w_hit1[gi]  = w_incl[gi] && (r_addr[gi] == qa1);
    assign w_hit2[gi]  = w_incl[gi] && (r_addr[gi] == qa2);
  end

  assign busy1 = (qa1 != c_XZR) && (|w_hit1);
  assign busy2 = (qa2 != c_XZR) && (|w_hit2);

`ifdef WBQ_FWD_EN
  logic [PW-1:0] w_ord [DEPTH];

  for (genvar gk = 0; gk < DEPTH; gk++) begin : g_order
    assign w_ord[gk] = r_head + PW'(gk);
  end

  // Walking oldest to youngest lets the last match win, i.e. the youngest pending write.
  always_comb begin
    fwd1 = 64'd0;
    fwd2 = 64'd0;
    for (int k = 0; k < DEPTH; k++) begin
      if (w_hit1[w_ord[k]] && (qa1 != c_XZR)) fwd1 = r_data[w_ord[k]];
      if (w_hit2[w_ord[k]] && (qa2 != c_XZR)) fwd2 = r_data[w_ord[k]];
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_wb_queue.sv
// tb_wb_queue: randomized and directed checks of wb_queue against a queue-based reference model.
`default_nettype none

module tb_wb_queue;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [4:0]  in_addr = '0;
  logic [63:0] in_data = '0;
  logic        hold = 1'b0;
  logic        we3;
  logic [4:0]  wa3;
  logic [63:0] wd3;
  logic [4:0]  qa1 = '0;
  logic [4:0]  qa2 = '0;
  logic        busy1;
  logic        busy2;
`ifdef WBQ_FWD_EN
  logic [63:0] fwd1;
  logic [63:0] fwd2;
`endif
  logic [$clog2(DEPTH):0] count;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [4:0]  a;
    logic [63:0] d;
  } ent_t;
  ent_t q[$];

  wb_queue #(.DEPTH(DEPTH)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_addr  (in_addr),
    .in_data  (in_data),
    .hold     (hold),
    .we3      (we3),
    .wa3      (wa3),
    .wd3      (wd3),
    .qa1      (qa1),
    .qa2      (qa2),
    .busy1    (busy1),
    .busy2    (busy2),
`ifdef WBQ_FWD_EN
    .fwd1     (fwd1),
    .fwd2     (fwd2),
`endif
    .count    (count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Returns {hit, data}: youngest queued write to qa, ignoring the head when it is draining.
  function automatic logic [64:0] lookup(input logic [4:0] qa, input bit skip_head);
    if (qa == 5'd31) return '0;
    for (int j = q.size() - 1; j >= (skip_head ? 1 : 0); j--)
      if (q[j].a == qa) return {1'b1, q[j].d};
    return '0;
  endfunction

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_count"}, 64'(count), 64'd0);
    chk({tag, "_in_ready"}, 64'(in_ready), 64'd1);
    chk({tag, "_we3"}, 64'(we3), 64'd0);
    chk({tag, "_wa3"}, 64'(wa3), 64'd0);
    chk({tag, "_wd3"}, wd3, 64'd0);
    chk({tag, "_busy1"}, 64'(busy1), 64'd0);
    chk({tag, "_busy2"}, 64'(busy2), 64'd0);
`ifdef WBQ_FWD_EN
    chk({tag, "_fwd1"}, fwd1, 64'd0);
    chk({tag, "_fwd2"}, fwd2, 64'd0);
`endif
  endtask

  // Called at a falling edge with inputs already driven: check, take the rising edge, update model.
  task automatic step();
    bit          exp_we;
    bit          acc;
    logic [64:0] l1;
    logic [64:0] l2;
    #1;
    exp_we = (q.size() != 0) && !hold;
    l1 = lookup(qa1, exp_we);
    l2 = lookup(qa2, exp_we);
    chk("count", 64'(count), 64'(q.size()));
    chk("in_ready", 64'(in_ready), 64'(q.size() < DEPTH));
    chk("we3", 64'(we3), 64'(exp_we));
    chk("wa3", 64'(wa3), (q.size() != 0) ? 64'(q[0].a) : 64'd0);
    chk("wd3", wd3, (q.size() != 0) ? q[0].d : 64'd0);
    chk("busy1", 64'(busy1), 64'(l1[64]));
    chk("busy2", 64'(busy2), 64'(l2[64]));
`ifdef WBQ_FWD_EN
    chk("fwd1", fwd1, l1[63:0]);
    chk("fwd2", fwd2, l2[63:0]);
`endif
    @(posedge clk);
    acc = in_valid && (q.size() < DEPTH);
    if (exp_we) void'(q.pop_front());
    if (acc && (in_addr != 5'd31)) q.push_back('{in_addr, in_data});
    @(negedge clk);
  endtask

  task automatic drive(input bit v, input logic [4:0] a, input logic [63:0] d);
    in_valid = v;
    in_addr  = a;
    in_data  = d;
  endtask

  function automatic logic [4:0] pick_addr();
    int r;
    r = $urandom_range(0, 8);
    return (r == 8) ? 5'd31 : 5'(r);
  endfunction

  initial begin
    #1;
    check_reset_outputs("por");
    @(negedge clk);
    reset_n = 1'b1;

    // Single write, one-cycle latency
    drive(1, 5'd5, 64'hAA); step();
    drive(0, 5'd0, 64'h0);  step(); step();

    // Fill under hold, fifth push refused, then in-order drain
    hold = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      drive(1, 5'(i), 64'(i * 16 + i)); step();
    end
    drive(1, 5'd8, 64'h88); step();
    drive(0, 5'd0, 64'h0); hold = 1'b0;
    for (int i = 0; i < 5; i++) step();

    // XZR result completes the handshake but is dropped
    drive(1, 5'd31, 64'hFF); step();
    drive(0, 5'd0, 64'h0); step(); step();

    // Busy with bypass exclusion of the draining head
    hold = 1'b1; qa1 = 5'd7; qa2 = 5'd9;
    drive(1, 5'd7, 64'h70); step();
    drive(1, 5'd9, 64'h90); step();
    drive(0, 5'd0, 64'h0); step();
    hold = 1'b0; step(); step(); step();

    // Youngest-wins for repeated destination
    hold = 1'b1; qa1 = 5'd6; qa2 = 5'd31;
    drive(1, 5'd6, 64'h1); step();
    drive(1, 5'd6, 64'h2); step();
    drive(0, 5'd0, 64'h0); step();
    hold = 1'b0; step(); step(); step();

    // Asynchronous reset with writes pending
    hold = 1'b1; qa1 = 5'd2; qa2 = 5'd3;
    for (int i = 1; i <= 3; i++) begin
      drive(1, 5'(i), 64'(100 + i)); step();
    end
    drive(0, 5'd0, 64'h0);
    #2 reset_n = 1'b0;
    #1 check_reset_outputs("async_rst");
    q.delete();
    @(negedge clk);
    reset_n = 1'b1; hold = 1'b0;
    for (int i = 0; i < 4; i++) step();

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      drive($urandom_range(0, 3) != 0, pick_addr(), {$urandom, $urandom});
      hold = ($urandom_range(0, 3) == 0);
      qa1  = pick_addr();
      qa2  = pick_addr();
      step();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/wb_queue.md
# wb_queue

Writeback queue on the write side of the pipelined datapath's register file. It accepts committed results (destination register, 64-bit value) from the pipeline over a valid/ready handshake and buffers them in order. It drives the register file write port (`we3`/`wa3`/`wd3`) with at most one write per cycle. It also reports, per read address, whether a buffered write to that register is still pending, so decode can stall or forward.

## Interface
Parameters:
- `DEPTH`, 4: queue entries; power of two, ≥ 2.

Ports:
- `clk`  in  1  rising-edge clock; the only clock.
- `reset_n`  in  1  reset, asynchronous, active-low.
- `in_valid`  in  1  producer has a result.
- `in_ready`  out  1  queue can accept; `count < DEPTH`.
- `in_addr`  in  5  destination register.
- `in_data`  in  64  result value.
- `hold`  in  1  suppresses draining this cycle.
- `we3`  out  1  register file write enable.
- `wa3`  out  5  register file write address.
- `wd3`  out  64  register file write data.
- `qa1`, `qa2`  in  5  query addresses; driven from decode `ra1`/`ra2`.
- `busy1`, `busy2`  out  1  a pending non-head write targets `qa1`/`qa2`.
- `fwd1`, `fwd2`  out  64  youngest pending data for `qa1`/`qa2`; present only with `WBQ_FWD_EN`.
- `count`  out  $clog2(DEPTH)+1  occupied entries.

## Operation
- **Storage:** circular FIFO of {addr, data} with head/tail pointers that wrap modulo DEPTH.
- **Enqueue:** a transfer occurs when `in_valid && in_ready`.
  - If `in_addr != 31`, write the entry at the tail and advance the tail.
  - If `in_addr == 31` (XZR), the handshake completes but nothing is stored; count is unchanged.
- **Drain:** `we3 = (count != 0) && !hold`, with `wa3`/`wd3` = head entry. The register file always accepts, so the head pops on every edge where `we3 = 1`.
- **Empty or hold:** when `count == 0` or `hold = 1`, `we3 = 0`. When `count == 0`, `wa3 = 0` and `wd3 = 0`. When `hold = 1` with `count != 0`, `wa3`/`wd3` show the head entry.
- **`in_ready`:** depends only on `count`, not on a same-cycle pop. When full, no enqueue occurs even if the head drains that cycle.
- **Simultaneous push and pop:** count is unchanged and both pointers advance.
- **Queries:**
  - `busyN` = OR of address matches over valid entries, excluding the head when `we3 = 1`. That head write is already visible through the register file's write-through bypass.
  - When `hold = 1`, the head is included in the match.
  - `qaN == 31` always gives `busyN = 0`.
- **Combinational paths:** `busyN`, `fwdN`, `we3`, `wa3`, `wd3` and `in_ready` are combinational from registered state plus `hold`, `qaN`. `count` is registered.

## Timing
- **Reset (`reset_n` low, asynchronous):** pointers and count go to 0. Outputs: `we3 = 0`, `wa3 = 0`, `wd3 = 0`, `in_ready = 1`, `busy1/2 = 0`, `fwd1/2 = 0`. Storage is not reset.
- **Reset mid-operation:** all pending writes are discarded; none reach the register file.
- **Latency:** a result accepted at edge N appears on `we3` during cycle N+1 if the queue was empty, and is written into the register file at edge N+1.
- **Throughput:** one enqueue and one drain per cycle.
- **Order:** strict FIFO; two writes to the same register retire in arrival order.

## Configuration
- **`WBQ_FWD_EN` defined:**
  - `fwd1`/`fwd2` exist.
  - Each carries the data of the youngest matching entry, using the same match set as `busyN`, or 0 if there is no match.
  - A priority search from tail-1 back toward the head selects the youngest.
- **`WBQ_FWD_EN` undefined:** `fwd1`/`fwd2` ports and the priority logic are absent. Decode must stall on `busyN`.

## Test plan
- **Reset then single write:** reset, then push {5, 0xAA} at edge N, `hold = 0` → cycle N+1 shows `we3 = 1`, `wa3 = 5`, `wd3 = 0xAA`; `count` returns to 0 after edge N+1.
- **Fill under hold:** hold = 1, push {1,0x11}, {2,0x22}, {3,0x33}, {4,0x44} → `count = 4`, `in_ready = 0`, `we3 = 0`. A fifth push is not accepted. Release hold → writes 1..4 retire on 4 consecutive edges in order.
- **XZR drop:** push {31, 0xFF} → handshake completes, `count` stays 0, `we3` never asserts.
- **Busy/bypass:** hold = 1, push {7,0x70} then {9,0x90}, `qa1 = 7` → `busy1 = 1`. Release hold → while {7} is the head with `we3 = 1`, `busy1 = 0`; `qa2 = 9` gives `busy2 = 1`.
- **Forward youngest (`WBQ_FWD_EN`):** hold = 1, push {6,0x1} then {6,0x2}, `qa1 = 6` → `fwd1 = 0x2`, `busy1 = 1`.
- **Async reset mid-stream:** 3 entries pending, pulse `reset_n` low between edges → outputs return to reset values immediately; no further `we3` after release.
